cordic_controller: RTL and testbench

CORDIC_CONTROLLER -- requirements
Module: cordic_controller

---
 rtl/cordic_controller_if.sv | 30 +++
 rtl/cordic_controller.sv | 140 ++++++++++++++
 tb/tb_cordic_controller.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/cordic_controller_if.sv
// Controller-to-CORDIC-core bus: load/step strobes and operands out, core state and overflow back.
// The master side is the controller, the slave side is the iterative core.
interface cordic_controller_if #(
  parameter int p_WIDTH = 32
);
  logic               o_core_load;
  logic [p_WIDTH-1:0] o_core_x;
  logic [p_WIDTH-1:0] o_core_y;
  logic [p_WIDTH-1:0] o_core_z;
  logic               o_core_system;
  logic               o_core_mode;
  logic               o_core_en;
  logic [4:0]         o_core_iter;
  logic [p_WIDTH-1:0] i_core_x;
  logic [p_WIDTH-1:0] i_core_y;
  logic [p_WIDTH-1:0] i_core_z;
  logic               i_core_overflow;

  modport master (
    output o_core_load, o_core_x, o_core_y, o_core_z,
    output o_core_system, o_core_mode, o_core_en, o_core_iter,
    input  i_core_x, i_core_y, i_core_z, i_core_overflow
  );

  modport slave (
    input  o_core_load, o_core_x, o_core_y, o_core_z,
    input  o_core_system, o_core_mode, o_core_en, o_core_iter,
    output i_core_x, i_core_y, i_core_z, i_core_overflow
  );
endinterface

// File: rtl/cordic_controller.sv
// Sequencer for an iterative CORDIC core: latches operands, loads the core, issues
// p_ITERATIONS step strobes with the per-step shift index, and captures the results.
module cordic_controller #(
  parameter int p_WIDTH      = 32,
  parameter int p_ITERATIONS = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic               i_system,
  input  logic               i_mode,
  input  logic [p_WIDTH-1:0] i_x_init,
  input  logic [p_WIDTH-1:0] i_y_init,
  input  logic [p_WIDTH-1:0] i_z_init,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_overflow,
  output logic [p_WIDTH-1:0] o_x_res,
  output logic [p_WIDTH-1:0] o_y_res,
  output logic [p_WIDTH-1:0] o_z_res,
  cordic_controller_if.master core
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITER, S_DONE} state_t;

  localparam logic [4:0] c_LAST = 5'(p_ITERATIONS - 1);

  state_t             r_state, w_state_next;
  logic [4:0]         r_count, w_count_next;
  logic               r_busy, r_done, r_overflow, r_load, r_en;
  logic [4:0]         r_iter;
  logic               r_system, r_mode;
  logic [p_WIDTH-1:0] r_x, r_y, r_z;
  logic [p_WIDTH-1:0] r_x_res, r_y_res, r_z_res;
  logic               w_busy, w_done, w_load, w_en;
  logic [4:0]         w_iter;
  logic               w_accept;

  assign w_accept = (r_state == S_IDLE) && i_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    case (r_state)
      S_IDLE: if (i_start) w_state_next = S_LOAD;
      S_LOAD: begin
        w_state_next = S_ITER;
        w_count_next = '0;
      end
      S_ITER: begin
        if (core.i_core_overflow || (r_count == c_LAST)) w_state_next = S_DONE;
        else                                             w_count_next = r_count + 5'd1;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so nothing leaves the block combinationally.
  // Hyperbolic steps start at shift 1 and repeat shifts 4 and 13 for convergence.
  always_comb begin
    w_busy = (w_state_next == S_LOAD) || (w_state_next == S_ITER);
    w_load = (w_state_next == S_LOAD);
    w_en   = (w_state_next == S_ITER);
    w_done = (w_state_next == S_DONE);
    w_iter = '0;
    if (w_state_next == S_ITER) begin
      if (r_system) w_iter = w_count_next;
      else          w_iter = w_count_next + 5'd1
                             - {4'd0, (w_count_next >= 5'd4)}
                             - {4'd0, (w_count_next >= 5'd14)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_load     <= 1'b0;
      r_en       <= 1'b0;
      r_iter     <= '0;
      r_overflow <= 1'b0;
      r_system   <= 1'b0;
      r_mode     <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_z        <= '0;
      r_x_res    <= '0;
      r_y_res    <= '0;
      r_z_res    <= '0;
    end else begin
      r_busy <= w_busy;
      r_done <= w_done;
      r_load <= w_load;
      r_en   <= w_en;
      r_iter <= w_iter;
      if (w_accept) begin
        r_system   <= i_system;
        r_mode     <= i_mode;
        r_x        <= i_x_init;
        r_y        <= i_y_init;
        r_z        <= i_z_init;
        r_overflow <= 1'b0;
      end else if ((r_state == S_ITER) && core.i_core_overflow) begin
        r_overflow <= 1'b1;
      end
      if (r_state == S_DONE) begin
        r_x_res <= core.i_core_x;
        r_y_res <= core.i_core_y;
        r_z_res <= core.i_core_z;
      end
    end
  end

  assign o_busy             = r_busy;
  assign o_done             = r_done;
  assign o_overflow         = r_overflow;
  assign o_x_res            = r_x_res;
  assign o_y_res            = r_y_res;
  assign o_z_res            = r_z_res;
  assign core.o_core_load   = r_load;
  assign core.o_core_en     = r_en;
  assign core.o_core_iter   = r_iter;
  assign core.o_core_system = r_system;
  assign core.o_core_mode   = r_mode;
  assign core.o_core_x      = r_x;
  assign core.o_core_y      = r_y;
  assign core.o_core_z      = r_z;

endmodule

// File: tb/tb_cordic_controller.sv
// Directed bench for cordic_controller; the bench plays the CORDIC core and checks sequencing.
module tb_cordic_controller;
  localparam int W = 32;
  localparam int N = 15;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_start = 1'b0, i_system = 1'b0, i_mode = 1'b0;
  logic [W-1:0] i_x_init = '0, i_y_init = '0, i_z_init = '0;
  logic         o_busy, o_done, o_overflow;
  logic [W-1:0] o_x_res, o_y_res, o_z_res;

  cordic_controller_if #(.p_WIDTH(W)) core_if ();

  cordic_controller #(.p_WIDTH(W), .p_ITERATIONS(N)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_system(i_system), .i_mode(i_mode),
    .i_x_init(i_x_init), .i_y_init(i_y_init), .i_z_init(i_z_init),
    .o_busy(o_busy), .o_done(o_done), .o_overflow(o_overflow),
    .o_x_res(o_x_res), .o_y_res(o_y_res), .o_z_res(o_z_res), .core(core_if)
  );

  always #5 clk = ~clk;

  int   n_err = 0;
  int   n_checks = 0;
  int   seq[64];
  int   n_en, lat, n_done, n_loads;
  logic bad_overlap, bad_busy, bad_load, ovf_at_done;
  int   hyp_exp[15] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic all_zero();
    return (|{o_busy, o_done, o_overflow, o_x_res, o_y_res, o_z_res,
              core_if.o_core_load, core_if.o_core_en, core_if.o_core_iter,
              core_if.o_core_system, core_if.o_core_mode,
              core_if.o_core_x, core_if.o_core_y, core_if.o_core_z}) === 1'b0;
  endfunction

  // Core state follows x+c, y+2c, z+3c in cycle c so the capture cycle is observable.
  task automatic run_op(input logic sys, input logic mode, input logic [W-1:0] x, y, z,
                        input int ovf_step, input bit poke);
    i_system = sys; i_mode = mode;
    i_x_init = x; i_y_init = y; i_z_init = z;
    n_en = 0; lat = 0; n_done = 0; n_loads = 0;
    bad_overlap = 0; bad_busy = 0; bad_load = 0; ovf_at_done = 0;
    i_start = 1'b1;
    tick();
    for (int c = 1; c <= 40; c++) begin
      i_start = 1'b0;
      core_if.i_core_overflow = 1'b0;
      core_if.i_core_x = x + W'(c);
      core_if.i_core_y = y + W'(2 * c);
      core_if.i_core_z = z + W'(3 * c);
      if (core_if.o_core_load && core_if.o_core_en) bad_overlap = 1;
      if (o_busy !== (core_if.o_core_load | core_if.o_core_en)) bad_busy = 1;
      if (core_if.o_core_load) begin
        n_loads++;
        if (core_if.o_core_x !== x || core_if.o_core_y !== y || core_if.o_core_z !== z ||
            core_if.o_core_system !== sys || core_if.o_core_mode !== mode || o_overflow !== 1'b0)
          bad_load = 1;
      end
      if (core_if.o_core_en) begin
        seq[n_en] = int'(core_if.o_core_iter);
        if (n_en == ovf_step) core_if.i_core_overflow = 1'b1;
        if (poke && n_en == 5) i_start = 1'b1;
        n_en++;
      end
      if (o_done) begin
        n_done++;
        lat = c;
        ovf_at_done = o_overflow;
        if (core_if.o_core_system !== sys || core_if.o_core_mode !== mode) bad_load = 1;
        if (poke) i_start = 1'b1;
        break;
      end
      tick();
    end
    tick();
    i_start = 1'b0;
    core_if.i_core_overflow = 1'b0;
  endtask

  initial begin
    int extra, found, load_cyc[4];
    logic [W-1:0] rx, ry, rz;
    core_if.i_core_x = '0; core_if.i_core_y = '0; core_if.i_core_z = '0;
    core_if.i_core_overflow = 1'b0;
    repeat (2) tick();
    chk("reset_outputs_zero", all_zero(), 1'b1);
    #2 rst_n = 1'b1;

    // circular rotation
    rx = 32'h26DD_3B6A; ry = 32'h0000_0000; rz = 32'h2000_0000;
    run_op(1'b1, 1'b1, rx, ry, rz, -1, 0);
    chk("circ_latency", lat, 17);
    chk("circ_en_count", n_en, N);
    chk("circ_loads", n_loads, 1);
    for (int k = 0; k < N; k++) chk($sformatf("circ_iter[%0d]", k), seq[k], k);
    chk("circ_load_values", bad_load, 0);
    chk("circ_overlap", bad_overlap, 0);
    chk("circ_busy", bad_busy, 0);
    chk("circ_ovf", ovf_at_done, 0);
    chk("circ_x_res", o_x_res, rx + 32'd17);
    chk("circ_y_res", o_y_res, ry + 32'd34);
    chk("circ_z_res", o_z_res, rz + 32'd51);
    chk("circ_busy_idle", o_busy, 0);

    // hyperbolic vectoring
    rx = 32'h2000_0000; ry = 32'h1000_0000; rz = 32'h0;
    run_op(1'b0, 1'b0, rx, ry, rz, -1, 0);
    chk("hyp_latency", lat, 17);
    chk("hyp_en_count", n_en, N);
    for (int k = 0; k < N; k++) chk($sformatf("hyp_iter[%0d]", k), seq[k], hyp_exp[k]);
    chk("hyp_load_values", bad_load, 0);
    chk("hyp_busy", bad_busy, 0);
    chk("hyp_z_res", o_z_res, rz + 32'd51);

    // overflow forced at step 6
    rx = 32'h1234_5678; ry = 32'h0BAD_F00D; rz = 32'h0000_1000;
    run_op(1'b1, 1'b1, rx, ry, rz, 6, 0);
    chk("ovf_en_count", n_en, 7);
    chk("ovf_latency", lat, 9);
    chk("ovf_flag_at_done", ovf_at_done, 1);
    chk("ovf_flag_held", o_overflow, 1);
    chk("ovf_x_res", o_x_res, rx + 32'd9);
    chk("ovf_overlap", bad_overlap, 0);

    // next op clears overflow on LOAD; starts poked during ITER and DONE are ignored
    rx = 32'h0000_0100; ry = 32'h0000_0200; rz = 32'h0000_0300;
    run_op(1'b1, 1'b0, rx, ry, rz, -1, 1);
    chk("clear_ovf_load", bad_load, 0);
    chk("clear_ovf_done", ovf_at_done, 0);
    chk("poke_latency", lat, 17);
    chk("poke_done_count", n_done, 1);
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      if (core_if.o_core_load || o_done) extra++;
      tick();
    end
    chk("poke_no_extra_op", extra, 0);
    chk("poke_ovf_clear", o_overflow, 0);

    // asynchronous reset at ITER step 8
    i_system = 1'b1; i_mode = 1'b1; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    found = 0; extra = 0;
    for (int c = 0; c < 40; c++) begin
      if (o_done) extra++;
      if (core_if.o_core_en && core_if.o_core_iter == 5'd8) begin found = 1; break; end
      tick();
    end
    chk("rst_reached_step8", found, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_zero", all_zero(), 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick();
      if (o_done) extra++;
    end
    chk("rst_no_done", extra, 0);
    chk("rst_held_zero", all_zero(), 1'b1);
    #2 rst_n = 1'b1;
    rx = 32'h0000_0AAA; ry = 32'h0000_0BBB; rz = 32'h0000_0CCC;
    run_op(1'b1, 1'b1, rx, ry, rz, -1, 0);
    chk("rst_restart_latency", lat, 17);
    chk("rst_restart_en", n_en, N);

    // back-to-back with i_start held
    i_system = 1'b1; i_mode = 1'b1; i_start = 1'b1;
    core_if.i_core_overflow = 1'b0;
    n_loads = 0; n_done = 0; bad_overlap = 0;
    for (int c = 1; c <= 80; c++) begin
      tick();
      if (core_if.o_core_load && core_if.o_core_en) bad_overlap = 1;
      if (o_done) n_done++;
      if (core_if.o_core_load) begin
        if (n_loads < 4) load_cyc[n_loads] = c;
        n_loads++;
        if (n_loads == 3) i_start = 1'b0;
      end
    end
    chk("b2b_loads", n_loads, 3);
    chk("b2b_dones", n_done, 3);
    chk("b2b_gap01", load_cyc[1] - load_cyc[0], N + 3);
    chk("b2b_gap12", load_cyc[2] - load_cyc[1], N + 3);
    chk("b2b_overlap", bad_overlap, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
